// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared definitions for the ALU controller with iterative M-extension engine:
// main-controller ALUOp classes, 4-bit ALU control codes, M-extension func3
// selectors and the handshake FSM state encoding.
package alu_ctrl_muldiv_pkg;

   // ALUOp classes from the main controller
   localparam logic [1:0] ALUOP_ST = 2'b00;
   localparam logic [1:0] ALUOP_BT = 2'b01;
   localparam logic [1:0] ALUOP_RT = 2'b10;
   localparam logic [1:0] ALUOP_IT = 2'b11;

   // ALU control codes driven to the datapath
   localparam logic [3:0] CTRL_ADD  = 4'b0000;
   localparam logic [3:0] CTRL_SUB  = 4'b0001;
   localparam logic [3:0] CTRL_AND  = 4'b0010;
   localparam logic [3:0] CTRL_OR   = 4'b0011;
   localparam logic [3:0] CTRL_XOR  = 4'b0100;
   localparam logic [3:0] CTRL_SLT  = 4'b0101;
   localparam logic [3:0] CTRL_SLTU = 4'b0110;
   localparam logic [3:0] CTRL_SLL  = 4'b0111;
   localparam logic [3:0] CTRL_SRL  = 4'b1000;
   localparam logic [3:0] CTRL_SRA  = 4'b1001;

   // func7 patterns that select an R-type sub-family
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // M-extension func3 selectors
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } md_state_t;

   // ALU code for the base (func7 = 0) R/I-type func3 set
   function automatic logic [3:0] f3_base_code(input logic [2:0] f3);
      logic [3:0] code;
      case (f3)
         3'b000:  code = CTRL_ADD;
         3'b001:  code = CTRL_SLL;
         3'b010:  code = CTRL_SLT;
         3'b011:  code = CTRL_SLTU;
         3'b100:  code = CTRL_XOR;
         3'b101:  code = CTRL_SRL;
         3'b110:  code = CTRL_OR;
         default: code = CTRL_AND;
      endcase
      return code;
   endfunction

   // Multiply ops have func3[2] clear, divide/remainder ops have it set
   function automatic logic f3_is_mul(input logic [2:0] f3);
      return ~f3[2];
   endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_iter.sv
// Iterative multiply/divide engine. Operates on operand magnitudes: XLEN
// shift-add steps for multiply or XLEN restoring-subtract steps for divide,
// then a two-cycle fix-up (sign application, then stable result select).
module muldiv_iter
   import alu_ctrl_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic            i_calc,
   input  logic            i_fix,
   input  logic [2:0]      i_func3,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   output logic            o_calc_last,
   output logic            o_fix_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   logic [2:0]        r_func3;
   logic              r_mul;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_opnd;
   logic              r_neg_p;
   logic              r_neg_r;
   logic              r_dz;
   logic [XLEN-1:0]   r_dividend;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_fix_ph;

   logic              w_a_sgn;
   logic              w_b_sgn;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_rem_sh;
   logic [XLEN:0]     w_diff;
   logic [2*XLEN-1:0] w_prod_neg;

   // Operand signedness per op and magnitudes taken at load time
   always_comb begin
      w_a_sgn = 1'b0;
      w_b_sgn = 1'b0;
      case (i_func3)
         F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
            w_a_sgn = i_op_a[XLEN-1];
            w_b_sgn = i_op_b[XLEN-1];
         end
         F3_MULHSU: w_a_sgn = i_op_a[XLEN-1];
         default: ;
      endcase
      w_mag_a = w_a_sgn ? -i_op_a : i_op_a;
      w_mag_b = w_b_sgn ? -i_op_b : i_op_b;
   end

   // One iteration step: partial-product add and trial subtraction
   always_comb begin
      w_sum      = {1'b0, r_hi} + {1'b0, r_opnd};
      w_rem_sh   = {r_hi, r_lo[XLEN-1]};
      w_diff     = w_rem_sh - {1'b0, r_opnd};
      w_prod_neg = -{r_hi, r_lo};
   end

   // Load, iterate XLEN times, then apply signs / divide-by-zero override
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_func3    <= '0;
         r_mul      <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_opnd     <= '0;
         r_neg_p    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dz       <= 1'b0;
         r_dividend <= '0;
         r_cnt      <= '0;
         r_fix_ph   <= 1'b0;
      end else if (i_load) begin
         r_func3    <= i_func3;
         r_mul      <= f3_is_mul(i_func3);
         // multiply: multiplicand in r_opnd, multiplier shifts out of r_lo
         // divide: divisor in r_opnd, dividend shifts out of r_lo
         r_opnd     <= f3_is_mul(i_func3) ? w_mag_a : w_mag_b;
         r_lo       <= f3_is_mul(i_func3) ? w_mag_b : w_mag_a;
         r_hi       <= '0;
         r_neg_p    <= w_a_sgn ^ w_b_sgn;
         r_neg_r    <= w_a_sgn;
         r_dz       <= ~f3_is_mul(i_func3) & (i_op_b == '0);
         r_dividend <= i_op_a;
         r_cnt      <= '0;
         r_fix_ph   <= 1'b0;
      end else if (i_calc) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (r_mul) begin
            if (r_lo[0]) begin
               r_hi <= w_sum[XLEN:1];
               r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end else begin
               r_hi <= {1'b0, r_hi[XLEN-1:1]};
               r_lo <= {r_hi[0], r_lo[XLEN-1:1]};
            end
         end else begin
            // remainder stays below the divisor, so XLEN bits always suffice
            if (!w_diff[XLEN]) begin
               r_hi <= w_diff[XLEN-1:0];
               r_lo <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
               r_hi <= w_rem_sh[XLEN-1:0];
               r_lo <= {r_lo[XLEN-2:0], 1'b0};
            end
         end
      end else if (i_fix && !r_fix_ph) begin
         r_fix_ph <= 1'b1;
         if (r_mul) begin
            if (r_neg_p) begin
               {r_hi, r_lo} <= w_prod_neg;
            end
         end else if (r_dz) begin
            // divide by zero: quotient all ones, remainder is the raw dividend
            r_lo <= '1;
            r_hi <= r_dividend;
         end else begin
            if (r_neg_p) begin
               r_lo <= -r_lo;
            end
            if (r_neg_r) begin
               r_hi <= -r_hi;
            end
         end
      end
   end

   // Low half carries product-low / quotient, high half product-high / remainder
   always_comb begin
      case (r_func3)
         F3_MUL, F3_DIV, F3_DIVU:                    o_result = r_lo;
         F3_MULH, F3_MULHSU, F3_MULHU, F3_REM, F3_REMU: o_result = r_hi;
         default:                                    o_result = r_lo;
      endcase
   end

   assign o_calc_last = (r_cnt == CNT_W'(XLEN - 1));
   assign o_fix_done  = r_fix_ph;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// ALU controller: combinational ALUOp/func3/func7 decode with illegal-encoding
// flag, plus the valid/ready handshake FSM that sequences M-extension ops
// through the iterative engine and stalls the pipeline while busy.
module alu_ctrl_muldiv
   import alu_ctrl_muldiv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        alu_op,
   input  logic [2:0]        func3,
   input  logic [6:0]        func7,
   output logic [CTRL_W-1:0] alu_control,
   output logic              illegal,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   output logic              md_op,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   md_result
);

   md_state_t         r_state;
   logic              r_busy;
   logic              r_in_ready;
   logic              r_out_valid;
   logic [XLEN-1:0]   r_md_result;

   logic [CTRL_W-1:0] w_ctrl;
   logic              w_illegal;
   logic              w_md_op;
   logic              w_accept;
   logic              w_calc_last;
   logic              w_fix_done;
   logic [XLEN-1:0]   w_result;

   // Decode ALUOp/func3/func7; unknown RT/IT encodings fall back to ADD
   always_comb begin
      w_ctrl    = CTRL_ADD;
      w_illegal = 1'b0;
      w_md_op   = 1'b0;
      case (alu_op)
         ALUOP_ST: w_ctrl = CTRL_ADD;
         ALUOP_BT: w_ctrl = CTRL_SUB;
         ALUOP_RT: begin
            if (func7 == F7_BASE) begin
               w_ctrl = f3_base_code(func3);
            end else if (func7 == F7_ALT && func3 == 3'b000) begin
               w_ctrl = CTRL_SUB;
            end else if (func7 == F7_ALT && func3 == 3'b101) begin
               w_ctrl = CTRL_SRA;
            end else if (func7 == F7_MULDIV) begin
               w_md_op = 1'b1;
            end else begin
               w_illegal = 1'b1;
            end
         end
         default: begin
            // immediate forms: func7 only qualifies the shift encodings
            case (func3)
               3'b001: begin
                  if (func7 == F7_BASE) w_ctrl = CTRL_SLL;
                  else                  w_illegal = 1'b1;
               end
               3'b101: begin
                  if (func7 == F7_BASE)     w_ctrl = CTRL_SRL;
                  else if (func7 == F7_ALT) w_ctrl = CTRL_SRA;
                  else                      w_illegal = 1'b1;
               end
               default: w_ctrl = f3_base_code(func3);
            endcase
         end
      endcase
   end

   assign w_accept = in_valid & r_in_ready & w_md_op & ~w_illegal;

   muldiv_iter #(
      .XLEN (XLEN)
   ) u_iter (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_accept),
      .i_calc      (r_state == ST_CALC),
      .i_fix       (r_state == ST_FIX),
      .i_func3     (func3),
      .i_op_a      (op_a),
      .i_op_b      (op_b),
      .o_calc_last (w_calc_last),
      .o_fix_done  (w_fix_done),
      .o_result    (w_result)
   );

   // Handshake FSM with registered busy/ready/valid/result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_md_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state    <= ST_CALC;
                  r_busy     <= 1'b1;
                  r_in_ready <= 1'b0;
               end
            end
            ST_CALC: begin
               if (w_calc_last) begin
                  r_state <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (w_fix_done) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
                  r_md_result <= w_result;
               end
            end
            default: begin
               // result stays put until the consumer takes it
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign alu_control = w_ctrl;
   assign illegal     = w_illegal;
   assign md_op       = w_md_op;
   assign in_ready    = r_in_ready;
   assign busy        = r_busy;
   assign out_valid   = r_out_valid;
   assign md_result   = r_md_result;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv: decode table, mul/div vectors with
// hand-computed results, handshake latency/hold, and mid-operation reset.
module tb_alu_ctrl_muldiv;

   localparam int XLEN = 32;
   localparam int LAT  = XLEN + 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      alu_op = 2'b00;
   logic [2:0]      func3 = 3'b000;
   logic [6:0]      func7 = 7'h00;
   logic [3:0]      alu_control;
   logic            illegal;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [XLEN-1:0] op_a = '0;
   logic [XLEN-1:0] op_b = '0;
   logic            md_op;
   logic            busy;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] md_result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_ctrl_muldiv #(
      .XLEN   (XLEN),
      .CTRL_W (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_op      (alu_op),
      .func3       (func3),
      .func7       (func7),
      .alu_control (alu_control),
      .illegal     (illegal),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .md_op       (md_op),
      .busy        (busy),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .md_result   (md_result)
   );

   typedef struct packed {
      logic [1:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [3:0] ctrl;
      logic       ill;
      logic       md;
   } dec_vec_t;

   dec_vec_t dec_tbl [14] = '{
      '{2'b00, 3'b000, 7'h00, 4'b0000, 1'b0, 1'b0},  // ST -> ADD
      '{2'b01, 3'b111, 7'h7F, 4'b0001, 1'b0, 1'b0},  // BT -> SUB
      '{2'b10, 3'b101, 7'h20, 4'b1001, 1'b0, 1'b0},  // RT SRA
      '{2'b10, 3'b101, 7'h02, 4'b0000, 1'b1, 1'b0},  // RT bad func7
      '{2'b10, 3'b100, 7'h00, 4'b0100, 1'b0, 1'b0},  // RT XOR
      '{2'b10, 3'b001, 7'h00, 4'b0111, 1'b0, 1'b0},  // RT SLL
      '{2'b10, 3'b011, 7'h00, 4'b0110, 1'b0, 1'b0},  // RT SLTU
      '{2'b10, 3'b000, 7'h20, 4'b0001, 1'b0, 1'b0},  // RT SUB
      '{2'b10, 3'b010, 7'h20, 4'b0000, 1'b1, 1'b0},  // RT alt SLT illegal
      '{2'b10, 3'b110, 7'h01, 4'b0000, 1'b0, 1'b1},  // RT M-ext
      '{2'b11, 3'b001, 7'h20, 4'b0000, 1'b1, 1'b0},  // IT SLLI bad func7
      '{2'b11, 3'b101, 7'h20, 4'b1001, 1'b0, 1'b0},  // IT SRAI
      '{2'b11, 3'b010, 7'h7F, 4'b0101, 1'b0, 1'b0},  // IT SLTI, imm bits
      '{2'b11, 3'b111, 7'h00, 4'b0010, 1'b0, 1'b0}   // IT ANDI
   };

   task automatic test_reset();
      alu_op = 2'b01;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ctrl got v=%b b=%b r=%b want v=0 b=0 r=1", out_valid, busy, in_ready);
      end
      checks++;
      if (md_result !== '0) begin
         errors++;
         $display("FAIL reset_result got %h want 00000000", md_result);
      end
      checks++;
      if (alu_control !== 4'b0001) begin
         errors++;
         $display("FAIL reset_decode got %b want 0001", alu_control);
      end
      rst_n = 1'b1;
      alu_op = 2'b00;
   endtask

   task automatic test_decode();
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         alu_op = dec_tbl[i].op;
         func3  = dec_tbl[i].f3;
         func7  = dec_tbl[i].f7;
         #1;
         checks++;
         if (alu_control !== dec_tbl[i].ctrl || illegal !== dec_tbl[i].ill || md_op !== dec_tbl[i].md) begin
            errors++;
            $display("FAIL decode_%0d got ctrl=%b ill=%b md=%b want ctrl=%b ill=%b md=%b",
                     i, alu_control, illegal, md_op, dec_tbl[i].ctrl, dec_tbl[i].ill, dec_tbl[i].md);
         end
      end
      @(negedge clk);
      alu_op = 2'b00; func3 = 3'b000; func7 = 7'h00;
   endtask

   // Present one M-extension op; returns #1 after the accepting edge
   task automatic start_md(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      @(negedge clk);
      alu_op = 2'b10; func7 = 7'h01; func3 = f3; op_a = a; op_b = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      // scramble inputs: the engine must work from latched values
      in_valid = 1'b0;
      op_a = 32'hDEADBEEF; op_b = '0;
      alu_op = 2'b00; func7 = 7'h00; func3 = 3'b000;
   endtask

   task automatic finish_md(input logic [XLEN-1:0] exp, input string nm, input int hold);
      int n;
      n = 0;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy got b=%b r=%b want b=1 r=0", nm, busy, in_ready);
      end
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (out_valid !== 1'b1 && n < 100);
      checks++;
      if (n != LAT) begin
         errors++;
         $display("FAIL %s_latency got %0d want %0d", nm, n, LAT);
      end
      checks++;
      if (md_result !== exp) begin
         errors++;
         $display("FAIL %s_result got %h want %h", nm, md_result, exp);
      end
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         // a new request while DONE must not disturb the held result
         alu_op = 2'b10; func7 = 7'h01; func3 = 3'b000; op_a = 32'h5; op_b = 32'h5;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || md_result !== exp) begin
            errors++;
            $display("FAIL %s_hold%0d got v=%b r=%h want v=1 r=%h", nm, k, out_valid, md_result, exp);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_release got v=%b b=%b r=%b want v=0 b=0 r=1", nm, out_valid, busy, in_ready);
      end
   endtask

   task automatic test_mul_handshake();
      start_md(3'b000, 32'h00000007, 32'hFFFFFFFD);
      finish_md(32'hFFFFFFEB, "mul_neg", 3);
   endtask

   task automatic test_mul_high();
      start_md(3'b001, 32'h80000000, 32'h80000000);
      finish_md(32'h40000000, "mulh", 0);
      start_md(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
      finish_md(32'hFFFFFFFE, "mulhu", 0);
      start_md(3'b010, 32'hFFFFFFFF, 32'h00000002);
      finish_md(32'hFFFFFFFF, "mulhsu", 0);
   endtask

   task automatic test_div();
      start_md(3'b100, 32'hFFFFFFF9, 32'h00000002);
      finish_md(32'hFFFFFFFD, "div_neg", 0);
      start_md(3'b110, 32'hFFFFFFF9, 32'h00000002);
      finish_md(32'hFFFFFFFF, "rem_neg", 0);
      start_md(3'b101, 32'h00000005, 32'h00000000);
      finish_md(32'hFFFFFFFF, "divu_zero", 0);
      start_md(3'b111, 32'h00000005, 32'h00000000);
      finish_md(32'h00000005, "remu_zero", 0);
      start_md(3'b110, 32'hFFFFFFF9, 32'h00000000);
      finish_md(32'hFFFFFFF9, "rem_zero", 0);
      start_md(3'b100, 32'h80000000, 32'hFFFFFFFF);
      finish_md(32'h80000000, "div_ovf", 0);
      start_md(3'b110, 32'h80000000, 32'hFFFFFFFF);
      finish_md(32'h00000000, "rem_ovf", 0);
   endtask

   task automatic test_reset_mid_op();
      start_md(3'b000, 32'h00001234, 32'h00005678);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || md_result !== '0) begin
         errors++;
         $display("FAIL midreset got v=%b b=%b r=%b res=%h want v=0 b=0 r=1 res=0",
                  out_valid, busy, in_ready, md_result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start_md(3'b000, 32'h00000003, 32'h00000004);
      finish_md(32'h0000000C, "mul_after_reset", 0);
   endtask

   initial begin
      test_reset();
      test_decode();
      test_mul_handshake();
      test_mul_high();
      test_div();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
